fifo_rr_arb: RTL
================

Name: fifo_rr_arb

Overview:
Round-robin arbiter that shares one downstream rdy/ack channel among N_REQ upstream requesters.
- Packet-aware: a grant is held from the first beat to the beat with last_i set, so packets never interleave.
- Output is a registered stage sustaining 1 beat/cycle. Sits in front of shared sinks (interconnect ports, shared FIFOs).
- Handshake convention: a beat transfers on any channel when rdy and ack are both high in the same cycle.

Parameters:
N_REQ, 4, number of requesters (1..16).
DATA_WIDTH, 32, beat data width.
ID_WIDTH, (N_REQ>1 ? $clog2(N_REQ) : 1), width of id_o (derived, not overridable).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- data_i  in  N_REQ*DATA_WIDTH  requester i beat at [i*DATA_WIDTH +: DATA_WIDTH].
- last_i  in  N_REQ  requester i: current beat ends its packet.
- rdy_i  in  N_REQ  requester i: beat valid.
- ack_o  out  N_REQ  requester i: beat accepted this cycle (combinational).
- data_o  out  DATA_WIDTH  registered output beat.
- last_o  out  1  registered last flag.
- id_o  out  ID_WIDTH  index of the requester that produced data_o.
- rdy_o  out  1  output beat valid (registered).
- ack_i  in  1  downstream accepts data_o.

Behaviour:
- Reset (rst_i=1 at posedge):
  - rdy_o=0, data_o=0, last_o=0, id_o=0.
  - state=IDLE, rr_ptr=0, owner=0.
  - ack_o forced to all-zero while rst_i=1.
- load_en = !rdy_o || ack_i. The output register accepts a new beat only when empty or draining in the same cycle.
- Winner selection (IDLE only): the first i with rdy_i[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping N_REQ-1 -> 0. Wrap is correct for non-power-of-two N_REQ.
- grant vector:
  - IDLE: one-hot winner, or zero if no rdy_i.
  - LOCK: one-hot owner.
- ack_o[i] = load_en && grant[i] && !rst_i. At most one bit is set per cycle.
- Transfer from requester g: rdy_i[g] && ack_o[g].
  - On the next edge: data_o<=data_i[g], last_o<=last_i[g], id_o<=g, rdy_o<=1.
- If no transfer and ack_i=1: rdy_o<=0. data_o, last_o and id_o hold their last values.
- If rdy_o=1 and ack_i=0: all outputs are held stable and ack_o is all-zero (backpressure propagates with no loss).
- FSM:
  - IDLE -> IDLE on a transfer with last=1, with rr_ptr<=(g+1) mod N_REQ.
  - IDLE -> LOCK on a transfer with last=0, with owner<=g.
  - IDLE holds if there is no transfer.
  - LOCK -> IDLE on an owner transfer with last=1, with rr_ptr<=(owner+1) mod N_REQ.
  - LOCK holds otherwise, including while the owner deasserts rdy_i. No other requester is granted during LOCK.
- rr_ptr updates only at packet end. Single-beat packets rotate priority each beat.
- Latency: 1 cycle from accepted input beat to rdy_o. Zero-bubble: back-to-back beats every cycle when ack_i stays 1, including across packet and requester boundaries.
- N_REQ=1: id_o is constantly 0; degenerates to a registered pipe stage with a lock FSM.
- Reset mid-packet: the output beat is discarded, FSM returns to IDLE, rr_ptr=0. Upstream partial packets are the requesters' concern.
- Protocol requirement on requesters: once rdy_i[i]=1, data_i and last_i for i stay stable until ack_o[i]=1.
- Assertions for the bench:
  - $onehot0(ack_o).
  - data_o, last_o and id_o stable while rdy_o && !ack_i.
  - id_o constant between a first beat and its last_o beat.

Test Plan:
1. Reset, then idle: rst_i=1 for 2 cycles with all rdy_i=1 -> ack_o=0000, rdy_o=0. First post-reset cycle -> ack_o=0001, and the next cycle shows id_o=0 and rdy_o=1.
2. Round-robin fairness: all 4 requesters hold rdy_i=1 and last_i=1, ack_i=1 for 8 cycles, data_i[i]=32'hA0+i -> id_o sequence 0,1,2,3,0,1,2,3. data_o matches each beat, and rdy_o stays 1 continuously (no bubbles).
3. Packet lock: requester 2 sends 3 beats (last only on the 3rd) while requester 1 holds rdy_i=1 -> ack_o[1]=0 throughout. Output shows id_o=2,2,2 with last_o=0,0,1, followed by id_o=1. Next priority order is 3,0,1,2.
4. Backpressure: ack_i=0 for 5 cycles while rdy_o=1 and requester 0 has a pending beat 32'hDEAD_BEEF -> data_o held and ack_o=0000. ack_i=1 -> held beat drains and the 32'hDEAD_BEEF beat appears in the next cycle.
5. Owner stall in LOCK: owner 3 sends a non-last beat, then drops rdy_i for 4 cycles while requester 0 is ready -> rdy_o falls to 0 and no grant goes to 0. Owner resumes with last=1 -> beat output, and requester 0 is granted next.
6. Reset mid-packet: requester 1 in LOCK after 2 beats, then rst_i=1 for 1 cycle -> rdy_o=0 and state IDLE. With requesters 0 and 1 ready after reset -> requester 0 is granted first (rr_ptr=0).

Source files
------------

// File: rtl/fifo_rr_arb.sv
// fifo_rr_arb: packet-aware round-robin arbiter feeding one registered output stage.
//
// Ports:
//   clk_i    - clock
//   rst_i    - synchronous active-high reset
//   data_i   - N_REQ packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   last_i   - per requester: current beat ends its packet
//   rdy_i    - per requester: beat valid
//   ack_o    - per requester: beat accepted this cycle (combinational, one-hot or zero)
//   data_o   - registered output beat
//   last_o   - registered last flag
//   id_o     - index of the requester that produced data_o
//   rdy_o    - output beat valid
//   ack_i    - downstream accepts data_o
//
// A grant is held from a packet's first beat until its last beat, so packets
// never interleave. Priority rotates only at packet end.
module fifo_rr_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  localparam int ID_WIDTH  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
  input  logic [N_REQ-1:0]            last_i,
  input  logic [N_REQ-1:0]            rdy_i,
  output logic [N_REQ-1:0]            ack_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        last_o,
  output logic [ID_WIDTH-1:0]         id_o,
  output logic                        rdy_o,
  input  logic                        ack_i
);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [ID_WIDTH-1:0]   r_owner;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_rdy;

  logic                  w_load_en;
  logic                  w_found;
  logic [ID_WIDTH-1:0]   w_winner;
  logic [ID_WIDTH-1:0]   w_gid;
  logic [N_REQ-1:0]      w_grant;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_xdata;
  logic                  w_xlast;
  int                    w_dist;
  int                    w_best;

  // Priority pointer successor; explicit wrap so non-power-of-two N_REQ works.
  function automatic logic [ID_WIDTH-1:0] f_next(input logic [ID_WIDTH-1:0] id);
    if (int'(id) == N_REQ - 1) return '0;
    else                       return id + 1'b1;
  endfunction

  // Output register can take a beat when empty or draining this cycle.
  assign w_load_en = !r_rdy || ack_i;

  // Winner = ready requester with the smallest rotational distance from rr_ptr.
  always_comb begin
    w_best   = N_REQ;
    w_dist   = 0;
    w_winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rdy_i[i]) begin
        w_dist = (i >= int'(r_rr_ptr)) ? i - int'(r_rr_ptr) : i + N_REQ - int'(r_rr_ptr);
        if (w_dist < w_best) begin
          w_best   = w_dist;
          w_winner = ID_WIDTH'(i);
        end
      end
    end
    w_found = (w_best < N_REQ);
  end

  // In LOCK the owner keeps the grant even while it is not ready.
  assign w_gid = (r_state == ST_LOCK) ? r_owner : w_winner;

  always_comb begin
    w_grant = '0;
    w_xdata = '0;
    w_xlast = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_WIDTH'(i) == w_gid) begin
        w_grant[i] = (r_state == ST_LOCK) || w_found;
        w_xdata    = data_i[i*DATA_WIDTH +: DATA_WIDTH];
        w_xlast    = last_i[i];
      end
    end
  end

  assign ack_o  = (w_load_en && !rst_i) ? w_grant : '0;
  assign w_xfer = |(ack_o & rdy_i);

  // ---- output register stage / FSM ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_data   <= '0;
      r_last   <= 1'b0;
      r_id     <= '0;
      r_rdy    <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_data <= w_xdata;
        r_last <= w_xlast;
        r_id   <= w_gid;
        r_rdy  <= 1'b1;
      end else if (ack_i) begin
        r_rdy  <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            if (w_xlast) begin
              r_rr_ptr <= f_next(w_gid);
            end else begin
              r_state <= ST_LOCK;
              r_owner <= w_gid;
            end
          end
        end
        ST_LOCK: begin
          if (w_xfer && w_xlast) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= f_next(r_owner);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_o = r_data;
  assign last_o = r_last;
  assign id_o   = r_id;
  assign rdy_o  = r_rdy;

endmodule
